sevenseg_reader: RTL and testbench

//  Reads a multiplexed 7-segment display bus (segment lines + one-hot digit select) and recovers
//  a 4-bit code per digit, the inverse of our 4-bit -> a..g segment decoders. Debounces each

---
 rtl/sevenseg_pkg.sv | 25 ++
 rtl/seg7_pattern_decode.sv | 33 +++
 rtl/sevenseg_reader.sv | 120 ++++++++++++
 tb/tb_sevenseg_reader.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/sevenseg_pkg.sv
// Shared 7-segment constants for the display readback blocks.
// Segment order is {a,b,c,d,e,f,g} with a in bit 6.
package sevenseg_pkg;

  localparam logic [6:0] SEG_0     = 7'h7E;
  localparam logic [6:0] SEG_1     = 7'h30;
  localparam logic [6:0] SEG_2     = 7'h6D;
  localparam logic [6:0] SEG_3     = 7'h79;
  localparam logic [6:0] SEG_4     = 7'h33;
  localparam logic [6:0] SEG_5     = 7'h5B;
  localparam logic [6:0] SEG_6     = 7'h5F;
  localparam logic [6:0] SEG_7     = 7'h70;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h7B;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  localparam logic [3:0] CODE_BLANK = 4'hF;
  localparam logic [3:0] CODE_ERR   = 4'hE;

  typedef enum logic {
    RD_WAIT     = 1'b0,
    RD_CAPTURED = 1'b1
  } rd_state_t;

endpackage

// File: rtl/seg7_pattern_decode.sv
// Combinational inverse of the 4-bit -> a..g segment decoder.
// A dark digit reads as CODE_BLANK without error; anything unrecognised is CODE_ERR with err set.
module seg7_pattern_decode
  import sevenseg_pkg::*;
(
  input  logic [6:0] pattern,
  output logic       err,
  output logic [3:0] code
);

  always_comb begin
    err  = 1'b0;
    code = CODE_ERR;
    case (pattern)
      SEG_0:     code = 4'd0;
      SEG_1:     code = 4'd1;
      SEG_2:     code = 4'd2;
      SEG_3:     code = 4'd3;
      SEG_4:     code = 4'd4;
      SEG_5:     code = 4'd5;
      SEG_6:     code = 4'd6;
      SEG_7:     code = 4'd7;
      SEG_8:     code = 4'd8;
      SEG_9:     code = 4'd9;
      SEG_BLANK: code = CODE_BLANK;
      default: begin
        code = CODE_ERR;
        err  = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/sevenseg_reader.sv
// Recovers per-digit codes from a multiplexed 7-segment bus, debounced per dwell, with a frame pulse.
// Define SEVENSEG_READER_SYNC_EN to pass seg_in/dig_sel through a 2-flop synchronizer first.
module sevenseg_reader
  import sevenseg_pkg::*;
#(
  parameter int DIGITS        = 4,
  parameter int STABLE_CYCLES = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [6:0]            seg_in,
  input  logic [DIGITS-1:0]     dig_sel,
  output logic [4*DIGITS-1:0]   value_out,
  output logic [DIGITS-1:0]     digit_err,
  output logic                  frame_valid
);

  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam int SW = DIGITS + 7;
  localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES);

  logic [6:0]        seg_s;
  logic [DIGITS-1:0] sel_s;

`ifdef SEVENSEG_READER_SYNC_EN
  logic [6:0]        seg_m;
  logic [DIGITS-1:0] sel_m;

  always_ff @(posedge clk) begin
    if (rst) begin
      seg_m <= '0;
      sel_m <= '0;
      seg_s <= '0;
      sel_s <= '0;
    end else begin
      seg_m <= seg_in;
      sel_m <= dig_sel;
      seg_s <= seg_m;
      sel_s <= sel_m;
    end
  end
`else
  assign seg_s = seg_in;
  assign sel_s = dig_sel;
`endif

  rd_state_t         state;
  logic [CW-1:0]     stab_cnt;
  logic [CW-1:0]     cnt_next;
  logic [SW-1:0]     prev_sample;
  logic [SW-1:0]     sample;
  logic [DIGITS-1:0] cap_mask;
  logic [DIGITS-1:0] mask_next;
  logic              sel_onehot;
  logic              same;
  logic              capture;
  logic              dec_err;
  logic [3:0]        dec_code;

  assign sample     = {sel_s, seg_s};
  assign sel_onehot = $onehot(sel_s);
  assign same       = (sample == prev_sample);
  assign mask_next  = cap_mask | sel_s;

  seg7_pattern_decode u_decode (
    .pattern (seg_s),
    .err     (dec_err),
    .code    (dec_code)
  );

  // An invalid select never accumulates stability, so a capture always needs a fresh valid dwell.
  always_comb begin
    cnt_next = '0;
    if (!sel_onehot)
      cnt_next = '0;
    else if (!same)
      cnt_next = CW'(1);
    else if (stab_cnt == CNT_MAX)
      cnt_next = CNT_MAX;
    else
      cnt_next = stab_cnt + 1'b1;
  end

  assign capture = (state == RD_WAIT) && sel_onehot && (cnt_next == CNT_MAX);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= RD_WAIT;
      stab_cnt    <= '0;
      prev_sample <= '0;
      cap_mask    <= '0;
      value_out   <= {DIGITS{CODE_BLANK}};
      digit_err   <= '0;
      frame_valid <= 1'b0;
    end else begin
      prev_sample <= sample;
      stab_cnt    <= cnt_next;
      frame_valid <= 1'b0;
      if (capture) begin
        for (int i = 0; i < DIGITS; i++) begin
          if (sel_s[i]) begin
            value_out[4*i +: 4] <= dec_code;
            digit_err[i]        <= dec_err;
          end
        end
        state <= RD_CAPTURED;
        // The write that completes the set both announces the frame and starts a new one.
        if (&mask_next) begin
          frame_valid <= 1'b1;
          cap_mask    <= '0;
        end else begin
          cap_mask <= mask_next;
        end
      end else if (!same || !sel_onehot) begin
        state <= RD_WAIT;
      end
    end
  end

endmodule

// File: tb/tb_sevenseg_reader.sv
// Self-checking bench for sevenseg_reader: a behavioural dwell model pushes expected captures
// onto a scoreboard that is popped and compared on the cycle the DUT should write.
module tb_sevenseg_reader;

  localparam int DIGITS = 4;
  localparam int STABLE = 3;

  logic                clk = 1'b0;
  logic                rst;
  logic [6:0]          seg_in;
  logic [DIGITS-1:0]   dig_sel;
  logic [4*DIGITS-1:0] value_out;
  logic [DIGITS-1:0]   digit_err;
  logic                frame_valid;

  always #5 clk = ~clk;

  sevenseg_reader #(
    .DIGITS        (DIGITS),
    .STABLE_CYCLES (STABLE)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .seg_in      (seg_in),
    .dig_sel     (dig_sel),
    .value_out   (value_out),
    .digit_err   (digit_err),
    .frame_valid (frame_valid)
  );

  typedef struct {
    int         due;
    int         dig;
    logic [3:0] code;
    logic       err;
    logic       frame;
  } exp_t;

  exp_t sb[$];
  exp_t ce;

  int checks = 0;
  int errors = 0;
  int cycle = 0;
  int exp_frames = 0;
  int seen_frames = 0;

  logic [DIGITS+6:0] m_prev;
  int                m_run;
  bit                m_cap;
  logic [DIGITS-1:0] m_mask;

  always @(posedge clk) cycle++;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  function automatic logic [4:0] ref_decode(input logic [6:0] p);
    case (p)
      7'h7E: return 5'h00;
      7'h30: return 5'h01;
      7'h6D: return 5'h02;
      7'h79: return 5'h03;
      7'h33: return 5'h04;
      7'h5B: return 5'h05;
      7'h5F: return 5'h06;
      7'h70: return 5'h07;
      7'h7F: return 5'h08;
      7'h7B: return 5'h09;
      7'h00: return 5'h0F;
      default: return 5'h1E;
    endcase
  endfunction

  task automatic modelReset();
    m_prev = '0;
    m_run  = 0;
    m_cap  = 1'b0;
    m_mask = '0;
  endtask

  // Drives one {dig_sel,seg_in} pair for n cycles, predicting each edge before it happens.
  task automatic applyStimulus(input logic [DIGITS-1:0] sel, input logic [6:0] seg, input int n);
    logic [DIGITS+6:0] pair;
    logic [4:0]        d;
    exp_t              e;
    pair = {sel, seg};
    for (int c = 0; c < n; c++) begin
      if ($countones(sel) != 1) begin
        m_run = 0;
        m_cap = 1'b0;
      end else if (pair == m_prev) begin
        if (m_run < STABLE) m_run++;
      end else begin
        m_run = 1;
        m_cap = 1'b0;
      end
      m_prev = pair;
      if (m_run == STABLE && !m_cap) begin
        m_cap  = 1'b1;
        d      = ref_decode(seg);
        e.due  = cycle + 1;
        e.dig  = 0;
        for (int i = 0; i < DIGITS; i++) if (sel[i]) e.dig = i;
        e.code = d[3:0];
        e.err  = d[4];
        m_mask = m_mask | sel;
        e.frame = (m_mask == {DIGITS{1'b1}});
        if (e.frame) begin
          m_mask = '0;
          exp_frames++;
        end
        sb.push_back(e);
      end
      dig_sel = sel;
      seg_in  = seg;
      @(negedge clk);
    end
  endtask

  task automatic resetDut();
    rst     = 1'b1;
    dig_sel = '0;
    seg_in  = '0;
    repeat (2) @(negedge clk);
    modelReset();
    sb.delete();
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0 && sb[0].due == cycle) begin
      ce = sb.pop_front();
      checkOutput($sformatf("value_d%0d", ce.dig), 32'(value_out[4*ce.dig +: 4]), 32'(ce.code));
      checkOutput($sformatf("err_d%0d", ce.dig), 32'(digit_err[ce.dig]), 32'(ce.err));
      checkOutput($sformatf("frame_d%0d", ce.dig), 32'(frame_valid), 32'(ce.frame));
    end
    if (frame_valid === 1'b1) seen_frames++;
  end

  logic [6:0] pats [12] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B,
                            7'h5F, 7'h70, 7'h7F, 7'h7B, 7'h00, 7'h01};

  initial begin
    modelReset();
    resetDut();
    checkOutput("reset_value", 32'(value_out), 32'hFFFF);
    checkOutput("reset_err", 32'(digit_err), 32'h0);
    checkOutput("reset_frame", 32'(frame_valid), 32'h0);
    rst = 1'b0;

    // Capture latency: nothing after two matching edges, code after the third.
    applyStimulus(4'b0001, 7'h79, 2);
    checkOutput("latency_early", 32'(value_out[3:0]), 32'hF);
    applyStimulus(4'b0001, 7'h79, 1);
    checkOutput("latency_value", 32'(value_out[3:0]), 32'h3);
    checkOutput("latency_err", 32'(digit_err[0]), 32'h0);

    applyStimulus(4'b0001, 7'h30, 4);
    applyStimulus(4'b0010, 7'h6D, 4);
    applyStimulus(4'b0100, 7'h79, 4);
    checkOutput("scan_no_frame_yet", 32'(seen_frames), 32'd0);
    applyStimulus(4'b1000, 7'h33, 4);
    checkOutput("scan_value", 32'(value_out), 32'h4321);
    checkOutput("scan_frames", 32'(seen_frames), 32'd1);

    // A short dwell on 79 must not overwrite digit 1 (would read 3).
    applyStimulus(4'b0010, 7'h79, 2);
    checkOutput("short_dwell", 32'(value_out[7:4]), 32'h2);
    applyStimulus(4'b0010, 7'h6D, 3);
    checkOutput("redwell_value", 32'(value_out[7:4]), 32'h2);

    applyStimulus(4'b0100, 7'h01, 3);
    checkOutput("unknown_value", 32'(value_out[11:8]), 32'hE);
    checkOutput("unknown_err", 32'(digit_err[2]), 32'h1);
    applyStimulus(4'b0100, 7'h00, 3);
    checkOutput("blank_value", 32'(value_out[11:8]), 32'hF);
    checkOutput("blank_err", 32'(digit_err[2]), 32'h0);
    checkOutput("bus_after_blank", 32'(value_out), 32'h4F21);

    applyStimulus(4'b0011, 7'h7E, 10);
    checkOutput("multi_sel_hold", 32'(value_out), 32'h4F21);

    applyStimulus(4'b0001, 7'h7E, 4);
    applyStimulus(4'b0010, 7'h30, 4);
    applyStimulus(4'b0100, 7'h6D, 4);
    checkOutput("partial_value", 32'(value_out), 32'h4210);
    resetDut();
    checkOutput("midframe_rst_value", 32'(value_out), 32'hFFFF);
    checkOutput("midframe_rst_err", 32'(digit_err), 32'h0);
    checkOutput("midframe_rst_frame", 32'(frame_valid), 32'h0);
    rst = 1'b0;
    applyStimulus(4'b0001, 7'h7F, 4);
    applyStimulus(4'b0010, 7'h7B, 4);
    applyStimulus(4'b0100, 7'h5F, 4);
    checkOutput("rescan_no_frame_yet", 32'(seen_frames), 32'd1);
    applyStimulus(4'b1000, 7'h70, 4);
    checkOutput("rescan_value", 32'(value_out), 32'h7698);
    checkOutput("rescan_frames", 32'(seen_frames), 32'd2);

    for (int k = 0; k < 40; k++) begin
      logic [DIGITS-1:0] sel;
      sel = (($urandom_range(0, 7)) == 0) ? 4'b0110 : 4'(1 << $urandom_range(0, DIGITS - 1));
      applyStimulus(sel, pats[$urandom_range(0, 11)], $urandom_range(1, 5));
    end
    applyStimulus(4'b0000, 7'h00, 3);
    checkOutput("frames_total", 32'(seen_frames), 32'(exp_frames));
    checkOutput("scoreboard_empty", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
